// File: rtl/spi_jstk_slave_if.sv
// Bus bundle for the SPI joystick responder: SPI pins plus the fabric-side frame signals.
// The slave modport is the responder's view; master is the SPI master / fabric view.
interface spi_jstk_slave_if #(
   parameter int FRAME_BITS = 40
);
   logic                  cs;
   logic                  sck;
   logic                  mosi;
   logic                  miso;
   logic [FRAME_BITS-1:0] tx_data;
   logic [FRAME_BITS-1:0] rx_data;
   logic                  rx_valid;
   logic                  frame_err;
   logic                  busy;
   logic [1:0]            led;

   modport slave (
      input  cs, sck, mosi, tx_data,
      output miso, rx_data, rx_valid, frame_err, busy, led
   );

   modport master (
      output cs, sck, mosi, tx_data,
      input  miso, rx_data, rx_valid, frame_err, busy, led
   );
endinterface

// File: rtl/spi_jstk_slave.sv
// SPI mode-0 responder for the 40-bit joystick frame, oversampled on clk50M.
// Optional LED command decode is built only when SPI_JSTK_LED_CMD_EN is defined.
module spi_jstk_slave #(
   parameter int FRAME_BITS  = 40,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk50M,
   input  logic             rst_n,
   spi_jstk_slave_if.slave  bus,
   output logic [1:0]       o_dbg_state
);

   localparam int CW = $clog2(FRAME_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
   localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_cs_hist;
   logic                   r_sck_hist;
   logic                   r_primed;
   logic                   r_armed;

   state_t                 r_state;
   state_t                 w_next;

   logic [FRAME_BITS-1:0]  r_tx_shift;
   logic [FRAME_BITS-1:0]  r_rx_shift;
   logic [FRAME_BITS-1:0]  r_rx_data;
   logic [CW-1:0]          r_bit_cnt;
   logic                   r_miso;
   logic                   r_rx_valid;
   logic                   r_frame_err;

   logic w_cs, w_sck, w_mosi;
   logic w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
   logic w_load, w_rx_shift, w_tx_shift, w_end, w_good, w_bad, w_busy;

   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_sync   <= '1;
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_hist   <= 1'b1;
         r_sck_hist  <= 1'b0;
         r_primed    <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         r_cs_hist   <= w_cs;
         r_sck_hist  <= w_sck;
         r_primed    <= 1'b1;
         // A frame already running at reset release drains the idle-high chain;
         // only a real high level on the pin arms cs_fall detection.
         r_armed     <= r_armed | (r_primed & r_cs_sync[0]);
      end
   end

   assign w_cs       = r_cs_sync[SYNC_STAGES-1];
   assign w_sck      = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs_fall  = r_armed & r_cs_hist & ~w_cs;
   assign w_cs_rise  = ~r_cs_hist & w_cs;
   assign w_sck_rise = ~w_cs & ~r_sck_hist & w_sck;
   assign w_sck_fall = ~w_cs & r_sck_hist & ~w_sck;

   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_cs_fall) w_next = ST_SHIFT;
         ST_SHIFT: if (w_cs_rise) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // cs_rise wins over an sck edge landing in the same cycle
   always_comb begin
      w_load     = 1'b0;
      w_rx_shift = 1'b0;
      w_tx_shift = 1'b0;
      w_end      = 1'b0;
      w_good     = 1'b0;
      w_bad      = 1'b0;
      w_busy     = 1'b0;
      case (r_state)
         ST_IDLE: w_load = w_cs_fall;
         ST_SHIFT: begin
            w_busy     = 1'b1;
            w_end      = w_cs_rise;
            w_rx_shift = ~w_cs_rise & w_sck_rise;
            w_tx_shift = ~w_cs_rise & w_sck_fall;
         end
         ST_DONE: begin
            w_good = (r_bit_cnt == CNT_FULL);
            w_bad  = (r_bit_cnt != CNT_FULL);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_shift  <= '0;
         r_rx_shift  <= '0;
         r_rx_data   <= '0;
         r_bit_cnt   <= '0;
         r_miso      <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_valid  <= w_good;
         r_frame_err <= w_bad;
         if (w_good) r_rx_data <= r_rx_shift;
         if (w_load) begin
            r_tx_shift <= bus.tx_data;
            r_bit_cnt  <= '0;
            r_miso     <= bus.tx_data[FRAME_BITS-1];
         end
         if (w_rx_shift) begin
            r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], w_mosi};
            if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + CW'(1);
         end
         if (w_tx_shift) begin
            r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
            r_miso     <= (r_bit_cnt >= CNT_FULL) ? 1'b0 : r_tx_shift[FRAME_BITS-2];
         end
         if (w_end) r_miso <= 1'b0;
      end
   end

`ifdef SPI_JSTK_LED_CMD_EN
   logic [1:0] r_led;

   // Command byte 100000xx in the frame's top bits sets the two LEDs
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n)
         r_led <= 2'b00;
      else if (w_good && (r_rx_shift[FRAME_BITS-1 -: 6] == 6'b100000))
         r_led <= r_rx_shift[FRAME_BITS-7 -: 2];
   end

   assign bus.led = r_led;
`else
   assign bus.led = 2'b00;
`endif

   assign bus.miso      = r_miso;
   assign bus.rx_data   = r_rx_data;
   assign bus.rx_valid  = r_rx_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.busy      = w_busy;
   assign o_dbg_state   = r_state;

endmodule

// File: doc/spi_jstk_slave.md
Name: spi_jstk_slave

Overview:
- SPI mode-0 responder (slave) for the 40-bit joystick-style frame. Lets the design emulate the joystick peripheral, or loop back against the on-board SPI master for self-test.
- All SPI inputs are oversampled on clk50M. A whole frame is received from MOSI while a 40-bit response is shifted out on MISO.
- The received frame is presented to fabric logic with a one-cycle valid strobe.

Parameters:
- FRAME_BITS, 40, number of bits per frame (MSB first, both directions).
- SYNC_STAGES, 2, flip-flop stages on each of sck/cs/mosi before edge detection (min 2).

Ports:
- clk50M  input  1  system clock, 50 MHz; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  SPI chip select, active low.
- sck  input  1  SPI clock from master, idle low.
- mosi  input  1  master out, slave in.
- miso  output  1  master in, slave out.
- tx_data  input  FRAME_BITS  response frame; sampled on the cs-assert event.
- rx_data  output  FRAME_BITS  last complete received frame; held until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_err  output  1  one-cycle pulse when cs deasserts after a bit count other than FRAME_BITS.
- busy  output  1  high while a frame is in progress (synced cs low).
- led  output  2  command LED bits (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): miso=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, led=0. Bit counter 0, shift registers 0, FSM=IDLE. Synchronizer flops reset to the idle levels: cs=1, sck=0, mosi=0.
- Synchronizer: SYNC_STAGES flops per input, plus one history flop for edge detection. Input-to-event latency is SYNC_STAGES+1 clk50M cycles. The master's SCK high and low times must each be at least 4 clk50M cycles. Faster SCK is outside spec and is not detected.
- Event definitions (on synced signals):
  - cs_fall = cs 1->0.
  - cs_rise = cs 0->1.
  - sck_rise / sck_fall = sck transitions, honoured only while synced cs=0.
- FSM states:
  - IDLE:
    - miso=0, busy=0.
    - On cs_fall: load tx_shift<=tx_data, bit_cnt<=0, miso<=tx_data[FRAME_BITS-1], busy<=1, go to SHIFT.
  - SHIFT:
    - sck_rise: rx_shift<={rx_shift[FRAME_BITS-2:0], mosi_sync}. bit_cnt increments, saturating at FRAME_BITS+1 (overrun marker).
    - sck_fall: tx_shift<<=1, miso<=new tx_shift MSB. Once bit_cnt>=FRAME_BITS, miso=0.
    - cs_rise: go to DONE; busy<=0 in the same cycle.
  - DONE (1 cycle):
    - If bit_cnt==FRAME_BITS: rx_data<=rx_shift, rx_valid=1.
    - Otherwise: frame_err=1 and rx_data is unchanged.
    - Always returns to IDLE.
- Simultaneous events in SHIFT: cs_rise takes priority over an sck edge in the same cycle; that sck edge is discarded.
- cs_fall while in DONE cannot occur, since cs high lasts at least one SCK period. If it does occur, it is ignored.
- Reset mid-frame: all state clears immediately. A frame still in progress after reset release is seen as cs low with no cs_fall. The block stays in IDLE until cs returns high and then falls again.
- tx_data changes after cs_fall do not affect the current frame.
- Overrun: bits beyond FRAME_BITS keep shifting rx_shift, but the frame is flagged frame_err and rx_data is not updated.

Optional Feature:
- Macro: SPI_JSTK_LED_CMD_EN.
- When defined:
  - On each good frame (the rx_valid cycle), if rx_data[FRAME_BITS-1:FRAME_BITS-6]==6'b100000, then led<=rx_data[FRAME_BITS-7:FRAME_BITS-8].
  - Otherwise led holds its value.
  - led resets to 0.
- When not defined: led is tied to 2'b00 and no decode logic is built.

Test Plan:
- Reset with cs=1, then release -> miso=0, rx_valid=0, busy=0, rx_data=0, led=0.
- tx_data=40'h12_3456_789A; master sends 40'h83_0000_0000 at SCK=clk50M/16 -> MISO bit stream reads 40'h12_3456_789A; one rx_valid pulse, rx_data=40'h83_0000_0000. With SPI_JSTK_LED_CMD_EN, led=2'b11; without it, led=2'b00.
- Master aborts after 17 bits (cs high) -> frame_err pulses once, rx_valid stays 0, rx_data keeps its previous value, busy falls.
- Master clocks 44 bits -> frame_err pulse; MISO=0 for bits 41-44; rx_data unchanged.
- Change tx_data to 40'hFF_FFFF_FFFF mid-frame -> MISO completes the previously latched value; the next frame returns 40'hFF_FFFF_FFFF.
- Assert rst_n=0 at bit 20, release while cs still low -> no rx_valid and no frame_err. The next full 40-bit frame is received correctly.
